// File: rtl/riscv_mem_pkg.sv
// Shared RV64 load/store definitions: func3 encodings, access sizes, MEM FSM states
// and small helpers for alignment checking and store byte-strobe generation.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [3:0] SIZE_B = 4'd1;
  localparam logic [3:0] SIZE_H = 4'd2;
  localparam logic [3:0] SIZE_W = 4'd4;
  localparam logic [3:0] SIZE_D = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Access width only depends on func3[1:0]; the unsigned-load bit does not matter here.
  function automatic logic misaligned(input logic [2:0] func3, input logic [2:0] off);
    logic res;
    case ({1'b0, func3[1:0]})
      F3_SB:   res = 1'b0;
      F3_SH:   res = off[0];
      F3_SW:   res = |off[1:0];
      F3_SD:   res = |off;
      default: res = |off;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] store_strobe(input logic [2:0] func3, input logic [2:0] off);
    logic [3:0] size;
    logic [8:0] mask;
    case ({1'b0, func3[1:0]})
      F3_SB:   size = SIZE_B;
      F3_SH:   size = SIZE_H;
      F3_SW:   size = SIZE_W;
      default: size = SIZE_D;
    endcase
    mask = (9'd1 << size) - 9'd1;
    return mask[7:0] << off;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load alignment: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them according to the load func3.
module load_align_ext
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      offset_i,
  input  logic [2:0]      func3_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted_s;

  always_comb begin
    shifted_s = rdata_i >> {offset_i, 3'b000};
    case (func3_i)
      F3_LB:   result_o = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
      F3_LH:   result_o = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
      F3_LW:   result_o = {{(XLEN-32){shifted_s[31]}}, shifted_s[31:0]};
      F3_LBU:  result_o = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
      F3_LWU:  result_o = {{(XLEN-32){1'b0}}, shifted_s[31:0]};
      F3_LD:   result_o = shifted_s;
      default: result_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: turns the EX/MEM load/store into a req/ack bus
// transaction, stalls the pipeline until it completes, and aborts on bus timeout.
module dmem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_read_m,
  input  logic            mem_write_m,
  input  logic [2:0]      func3_m,
  input  logic [XLEN-1:0] addr_m,
  input  logic [XLEN-1:0] wdata_m,
  output logic            stall_m,
  output logic [XLEN-1:0] load_data_m,
  output logic            misalign_m,
  output logic            timeout_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [7:0]      bus_wstrb,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [XLEN-1:0]   bus_addr_q;
  logic [XLEN-1:0]   bus_wdata_q;
  logic [7:0]        bus_wstrb_q;
  logic [XLEN-1:0]   load_data_q;
  logic              timeout_q;
  logic [2:0]        func3_q;
  logic [2:0]        off_q;

  logic              access_s;
  logic              misal_s;
  logic              start_s;
  logic              expired_s;
  logic [XLEN-1:0]   load_ext_s;

  assign access_s  = mem_read_m | mem_write_m;
  assign misal_s   = misaligned(func3_m, addr_m[2:0]);
  assign start_s   = (state_q == ST_IDLE) & access_s & ~misal_s;
  assign expired_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // The stall must rise in the same cycle the access appears so EX/MEM is held from cycle 0.
  assign stall_m    = ~reset & (start_s | (state_q == ST_BUSY));
  assign misalign_m = ~reset & (state_q == ST_IDLE) & access_s & misal_s;

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign load_data_m = load_data_q;
  assign timeout_err = timeout_q;

  load_align_ext #(.XLEN(XLEN)) u_load_align_ext (
    .rdata_i  (bus_rdata),
    .offset_i (off_q),
    .func3_i  (func3_q),
    .result_o (load_ext_s)
  );

  // Access sequencer: IDLE -> BUSY (request held) -> DONE (result/abort) -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= 8'h00;
      load_data_q <= '0;
      timeout_q   <= 1'b0;
      func3_q     <= 3'b000;
      off_q       <= 3'b000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timeout_q <= 1'b0;
          if (start_s) begin
            bus_addr_q  <= {addr_m[XLEN-1:3], 3'b000};
            bus_we_q    <= mem_write_m;
            bus_wdata_q <= wdata_m << {addr_m[2:0], 3'b000};
            bus_wstrb_q <= mem_write_m ? store_strobe(func3_m, addr_m[2:0]) : 8'h00;
            func3_q     <= func3_m;
            off_q       <= addr_m[2:0];
            bus_req_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // An ack on the final allowed cycle still completes the access normally.
          if (bus_ack) begin
            load_data_q <= load_ext_s;
            bus_req_q   <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_DONE;
          end else if (expired_s) begin
            load_data_q <= '0;
            bus_req_q   <= 1'b0;
            timeout_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          timeout_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          bus_req_q <= 1'b0;
          timeout_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl with a shortened bus timeout.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [2:0]  func3_m;
  logic [63:0] addr_m;
  logic [63:0] wdata_m;
  logic        stall_m;
  logic [63:0] load_data_m;
  logic        misalign_m;
  logic        timeout_err;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_ack;
  logic [63:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  dmem_access_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read_m  (mem_read_m),
    .mem_write_m (mem_write_m),
    .func3_m     (func3_m),
    .addr_m      (addr_m),
    .wdata_m     (wdata_m),
    .stall_m     (stall_m),
    .load_data_m (load_data_m),
    .misalign_m  (misalign_m),
    .timeout_err (timeout_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one access from IDLE; ack_at = BUSY cycle (1-based) carrying the ack, 0 = never.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input int ack_at, input logic [63:0] rdata,
                            output int stall_cycles, output int req_cycles,
                            output logic [63:0] ld, output logic terr,
                            output logic [63:0] addr_seen, output logic [63:0] wdata_seen,
                            output logic [7:0] strb_seen, output logic we_seen);
    logic done;
    done = 1'b0;
    stall_cycles = 0;
    req_cycles = 0;
    ld = '0;
    terr = 1'b0;
    addr_seen = '0;
    wdata_seen = '0;
    strb_seen = 8'h00;
    we_seen = 1'b0;
    mem_read_m = rd;
    mem_write_m = wr;
    func3_m = f3;
    addr_m = addr;
    wdata_m = wdata;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (stall_m) stall_cycles++;
      if (bus_req) begin
        req_cycles++;
        addr_seen = bus_addr;
        wdata_seen = bus_wdata;
        strb_seen = bus_wstrb;
        we_seen = bus_we;
        bus_rdata = rdata;
        bus_ack = (req_cycles == ack_at);
      end else if (c > 0 && !stall_m) begin
        done = 1'b1;
        ld = load_data_m;
        terr = timeout_err;
      end
      if (!done) begin
        tick();
        bus_ack = 1'b0;
        #1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_completes: done=%0b required=1 (addr %h)", done, addr);
    end
    mem_read_m = 1'b0;
    mem_write_m = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_read_m = 1'b0;
    mem_write_m = 1'b0;
    func3_m = 3'b000;
    addr_m = '0;
    wdata_m = '0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    tick();
    tick();
    checks++;
    if ({stall_m, misalign_m, timeout_err, bus_req, bus_we} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {stall_m, misalign_m, timeout_err, bus_req, bus_we});
    end
    checks++;
    if ({bus_addr, bus_wdata, bus_wstrb, load_data_m} !== {64'h0, 64'h0, 8'h00, 64'h0}) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h strb=%h ld=%h required all 0", bus_addr, bus_wdata, bus_wstrb, load_data_m);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_dword();
    int sc, rc;
    logic [63:0] ld, a, w;
    logic [7:0] s;
    logic t, we;
    run_access(1'b1, 1'b0, 3'b011, 64'h1000, 64'h0, 1, 64'h1122334455667788,
               sc, rc, ld, t, a, w, s, we);
    checks++;
    if (sc !== 2) begin errors++; $display("FAIL ld_stall_cycles: got %0d required 2", sc); end
    checks++;
    if (rc !== 1) begin errors++; $display("FAIL ld_req_cycles: got %0d required 1", rc); end
    checks++;
    if (ld !== 64'h1122334455667788) begin errors++; $display("FAIL ld_data: got %h required 1122334455667788", ld); end
    checks++;
    if ({a, s, we, t} !== {64'h1000, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ld_bus: addr=%h strb=%h we=%b terr=%b required 1000/00/0/0", a, s, we, t);
    end
  endtask

  task automatic test_load_extend();
    int sc, rc;
    logic [63:0] ld, a, w;
    logic [7:0] s;
    logic t, we;
    run_access(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 1, 64'h0000000080000000, sc, rc, ld, t, a, w, s, we);
    checks++;
    if (ld !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h required FFFFFFFFFFFFFF80", ld); end
    checks++;
    if (a !== 64'h1000) begin errors++; $display("FAIL lb_addr: got %h required 1000", a); end
    run_access(1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 1, 64'h0000000080000000, sc, rc, ld, t, a, w, s, we);
    checks++;
    if (ld !== 64'h0000000000000080) begin errors++; $display("FAIL lbu_zext: got %h required 80", ld); end
    run_access(1'b1, 1'b0, 3'b010, 64'h1004, 64'h0, 3, 64'h8000000100000000, sc, rc, ld, t, a, w, s, we);
    checks++;
    if (ld !== 64'hFFFFFFFF80000001) begin errors++; $display("FAIL lw_sext: got %h required FFFFFFFF80000001", ld); end
    checks++;
    if (sc !== 4 || rc !== 3) begin errors++; $display("FAIL lw_latency: stall=%0d req=%0d required 4/3", sc, rc); end
    run_access(1'b1, 1'b0, 3'b110, 64'h1004, 64'h0, 1, 64'h8000000100000000, sc, rc, ld, t, a, w, s, we);
    checks++;
    if (ld !== 64'h0000000080000001) begin errors++; $display("FAIL lwu_zext: got %h required 80000001", ld); end
    run_access(1'b1, 1'b0, 3'b001, 64'h1006, 64'h0, 2, 64'hABCD000000000000, sc, rc, ld, t, a, w, s, we);
    checks++;
    if (ld !== 64'hFFFFFFFFFFFFABCD) begin errors++; $display("FAIL lh_sext: got %h required FFFFFFFFFFFFABCD", ld); end
  endtask

  task automatic test_store();
    int sc, rc;
    logic [63:0] ld, a, w;
    logic [7:0] s;
    logic t, we;
    run_access(1'b0, 1'b1, 3'b001, 64'h2006, 64'h000000000000BEEF, 1, 64'h0, sc, rc, ld, t, a, w, s, we);
    checks++;
    if ({a, s, w, we} !== {64'h2000, 8'hC0, 64'hBEEF000000000000, 1'b1}) begin
      errors++;
      $display("FAIL sh_bus: addr=%h strb=%h wdata=%h we=%b required 2000/C0/BEEF000000000000/1", a, s, w, we);
    end
    run_access(1'b0, 1'b1, 3'b000, 64'h4005, 64'h000000000000005A, 1, 64'h0, sc, rc, ld, t, a, w, s, we);
    checks++;
    if ({a, s, w} !== {64'h4000, 8'h20, 64'h00005A0000000000}) begin
      errors++;
      $display("FAIL sb_bus: addr=%h strb=%h wdata=%h required 4000/20/00005A0000000000", a, s, w);
    end
    run_access(1'b0, 1'b1, 3'b011, 64'h4008, 64'h0123456789ABCDEF, 1, 64'h0, sc, rc, ld, t, a, w, s, we);
    checks++;
    if ({a, s, w} !== {64'h4008, 8'hFF, 64'h0123456789ABCDEF}) begin
      errors++;
      $display("FAIL sd_bus: addr=%h strb=%h wdata=%h required 4008/FF/0123456789ABCDEF", a, s, w);
    end
  endtask

  task automatic test_read_write_both();
    int sc, rc;
    logic [63:0] ld, a, w;
    logic [7:0] s;
    logic t, we;
    run_access(1'b1, 1'b1, 3'b010, 64'h4004, 64'h00000000DEADBEEF, 1, 64'h0, sc, rc, ld, t, a, w, s, we);
    checks++;
    if ({we, s, w} !== {1'b1, 8'hF0, 64'hDEADBEEF00000000}) begin
      errors++;
      $display("FAIL both_is_write: we=%b strb=%h wdata=%h required 1/F0/DEADBEEF00000000", we, s, w);
    end
  endtask

  task automatic test_misalign();
    int req_seen;
    req_seen = 0;
    mem_read_m = 1'b1;
    func3_m = 3'b010;
    addr_m = 64'h3002;
    #1;
    checks++;
    if ({misalign_m, stall_m} !== 2'b10) begin
      errors++;
      $display("FAIL misalign_flag: misalign=%b stall=%b required 1/0", misalign_m, stall_m);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus_req) req_seen++;
    end
    checks++;
    if (req_seen !== 0) begin errors++; $display("FAIL misalign_no_req: got %0d req cycles required 0", req_seen); end
    mem_read_m = 1'b0;
    #1;
    checks++;
    if (misalign_m !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b required 0", misalign_m); end
    tick();
  endtask

  task automatic test_timeout();
    int sc, rc;
    int bad;
    logic [63:0] ld, a, w;
    logic [7:0] s;
    logic t, we;
    run_access(1'b1, 1'b0, 3'b011, 64'h5000, 64'h0, 0, 64'hCAFECAFECAFECAFE, sc, rc, ld, t, a, w, s, we);
    checks++;
    if (rc !== 4) begin errors++; $display("FAIL timeout_req_cycles: got %0d required 4", rc); end
    checks++;
    if ({t, ld} !== {1'b1, 64'h0}) begin errors++; $display("FAIL timeout_done: terr=%b ld=%h required 1/0", t, ld); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b required 0 after DONE", timeout_err); end
    bad = 0;
    bus_ack = 1'b1;
    bus_rdata = 64'h1234123412341234;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus_req || stall_m || load_data_m !== 64'h0) bad++;
    end
    bus_ack = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL late_ack_ignored: %0d bad cycles required 0", bad); end
  endtask

  task automatic test_reset_mid_busy();
    int sc, rc;
    logic [63:0] ld, a, w;
    logic [7:0] s;
    logic t, we;
    mem_read_m = 1'b1;
    func3_m = 3'b011;
    addr_m = 64'h6000;
    tick();
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL busy_before_reset: bus_req=%b required 1", bus_req); end
    reset = 1'b1;
    mem_read_m = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus_req, stall_m} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_busy: req=%b stall=%b required 0/0", bus_req, stall_m);
    end
    tick();
    run_access(1'b1, 1'b0, 3'b011, 64'h6008, 64'h0, 2, 64'h0F0E0D0C0B0A0908, sc, rc, ld, t, a, w, s, we);
    checks++;
    if ({ld, t} !== {64'h0F0E0D0C0B0A0908, 1'b0} || sc !== 3) begin
      errors++;
      $display("FAIL after_reset_ld: ld=%h terr=%b stall=%0d required 0F0E0D0C0B0A0908/0/3", ld, t, sc);
    end
  endtask

  initial begin
    test_reset();
    test_load_dword();
    test_load_extend();
    test_store();
    test_read_write_both();
    test_misalign();
    test_timeout();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
